uart_frame_loader: RTL and testbench
====================================

// Module: uart_frame_loader
// PURPOSE
//  Host-to-FPGA download engine: parses byte frames from uart_rx, writes N words into one of CHANNELS
//  memory targets (screen/font/colour RAM, SDRAM bridge) or sets a mode register, and reports status via uart_tx.
//  Parametrised successor of the fixed 16-bit, single-target UART loader; adds backpressure, fill, checksum, timeout.
// PARAMETERS
//  ADDR_W       16          word address width; address field = ADDR_B = ceil(ADDR_W/8) bytes
//  DATA_W       16          write word width, multiple of 8; DATA_B = DATA_W/8 bytes per word
//  CHANNELS     4           number of write targets, 1..16
//  TIMEOUT_CYC  27_000_000  max clk cycles between bytes inside a frame (1 s at 27 MHz)
// PORTS
//  clk            in   1        system clock (27 MHz domain of uart_rx/uart_tx)
//  rst            in   1        synchronous reset, active-high
//  rx_data        in   8        byte from uart_rx
//  rx_data_valid  in   1        byte strobe, 1 cycle
//  rx_data_ready  out  1        loader can accept a byte
//  tx_data        out  8        status byte to uart_tx
//  tx_data_valid  out  1        held until tx_data_ready
//  tx_data_ready  in   1        uart_tx accepted byte
//  wr_en          out  1        write request, held until wr_ready
//  wr_ready       in   1        target accepts write this cycle
//  wr_sel         out  4        target channel index
//  wr_addr        out  ADDR_W   word address
//  wr_data        out  DATA_W   word data
//  mode_q         out  8        mode register
//  mode_we        out  1        1-cycle pulse when mode_q updated
//  busy           out  1        state != IDLE
// BEHAVIOUR
//  Frame: CMD, then fields little-endian, then CSUM; CSUM chosen so 8-bit sum of all frame bytes == 0x00.
//  CMD 0x00..CHANNELS-1 WRITE: ADDR(ADDR_B), CNT(2), CNT+1 words of DATA_B bytes, CSUM.
//  CMD 0x40+ch FILL: ADDR, CNT, one word, CSUM; word written CNT+1 times at successive addresses.
//  CMD 0x4D MODE: one mode byte, CSUM; mode_q/mode_we update only if CSUM valid.
//  Other CMD: send 0x3F, stay IDLE.
//  States: IDLE -> ADDR -> CNT -> DATA -> WRITE -> (DATA | FILL_W | CSUM) -> RESP -> IDLE; MODE -> CSUM.
//  WRITE: wr_en=1 with stable sel/addr/data until wr_en&&wr_ready; then addr+1 mod 2^ADDR_W, CNT-1;
//   last word when CNT==0 before decrement; CNT=0 -> exactly 1 word, CNT=0xFFFF -> 65536 words.
//  FILL_W: repeats WRITE without consuming bytes; rx_data_ready=0 in WRITE and FILL_W, 1 elsewhere except RESP.
//  Writes are not retracted on bad CSUM; CSUM only selects response.
//  RESP: tx 0x06 ACK if CSUM ok and no error, 0x15 NAK otherwise; tx_data_valid held until tx_data_ready.
//  Overrun: rx_data_valid while rx_data_ready=0 sets sticky err (cleared in IDLE); frame ends with NAK.
//  Timeout: wait counter cleared on every accepted byte and in WRITE/FILL_W; reaching TIMEOUT_CYC in
//   ADDR/CNT/DATA/MODE/CSUM aborts -> tx 0x18, IDLE. Counter idle in IDLE.
//  Multi-byte fields assemble LSB-first; byte counter width clog2(max(ADDR_B,DATA_B,2)).
//  Reset: IDLE, rx_data_ready=1, tx_data_valid=0, tx_data=0, wr_en=0, wr_sel/addr/data=0, mode_q=0,
//   mode_we=0, busy=0, err=0. Reset mid-write drops wr_en next cycle; partial frame discarded.
//  wr_ready asserted with wr_en=0 is ignored; wr_ready may stay low indefinitely (no timeout in WRITE).
// STRUCTURE
//  Package uart_frame_pkg: CMD_MODE=8'h4D, CMD_FILL_BASE=8'h40, ACK=8'h06, NAK=8'h15, ABORT=8'h18,
//   BADCMD=8'h3F, state enum.
//  Sub-module frame_field_shift: LSB-first byte assembler (width param, load/clear/done) reused for ADDR, CNT, DATA.
// TESTING
//  WRITE ch2 ADDR=0x1234 CNT=1 data 0xBEEF,0xCAFE, good CSUM -> writes (2,0x1234,0xBEEF),(2,0x1235,0xCAFE); tx 0x06.
//  FILL ch0 ADDR=0xFFFE CNT=3 word 0x00AA, wr_ready toggling -> 4 writes at 0xFFFE,0xFFFF,0x0000,0x0001; ACK.
//  MODE 0x07 bad CSUM -> mode_q unchanged, mode_we never pulses, tx 0x15; good CSUM -> mode_q=0x07, 1-cycle pulse.
//  WRITE frame stops after ADDR, TIMEOUT_CYC=1000 -> tx 0x18 at cycle 1000 after last byte, back to IDLE.
//  CMD 0x09 with CHANNELS=4 -> tx 0x3F; next valid frame processed normally.
//  rst asserted while wr_en=1 and wr_ready=0 -> all outputs at reset values next cycle; no further writes.

Source files
------------

// File: rtl/uart_frame_loader_pkg.sv
// Shared opcodes, response codes, FSM state type and small helpers for the UART frame loader.
package uart_frame_pkg;

    localparam logic [7:0] CMD_MODE      = 8'h4D;
    localparam logic [7:0] CMD_FILL_BASE = 8'h40;
    localparam logic [7:0] ACK           = 8'h06;
    localparam logic [7:0] NAK           = 8'h15;
    localparam logic [7:0] ABORT         = 8'h18;
    localparam logic [7:0] BADCMD        = 8'h3F;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_ADDR   = 4'd1,
        S_CNT    = 4'd2,
        S_DATA   = 4'd3,
        S_WRITE  = 4'd4,
        S_FILL_W = 4'd5,
        S_MODE   = 4'd6,
        S_CSUM   = 4'd7,
        S_RESP   = 4'd8
    } state_e;

    // Running 8-bit frame checksum; a good frame sums to zero.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/uart_frame_loader_field_shift.sv
// LSB-first byte assembler for multi-byte frame fields; value shows the field including the byte
// being loaded this cycle so the caller can capture it on the same edge as last.
import uart_frame_pkg::*;

module frame_field_shift #(
    parameter int NB    = 2,
    parameter int IDX_W = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic [7:0]        din,
    output logic              last,
    output logic [NB*8-1:0]   value
);

    logic [IDX_W-1:0] idx_r;
    logic [NB*8-1:0]  acc_r;
    logic [NB*8-1:0]  value_s;

    // Merge the incoming byte into its lane of the accumulated field.
    always_comb begin
        value_s = acc_r;
        if (load) begin
            value_s[idx_r*8 +: 8] = din;
        end else begin
            value_s = acc_r;
        end
    end

    assign value = value_s;
    assign last  = load && (idx_r == IDX_W'(NB - 1));

    // Byte lane index and accumulator; index wraps after the final byte of a field.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            idx_r <= '0;
            acc_r <= '0;
        end else if (load) begin
            acc_r <= value_s;
            idx_r <= last ? '0 : idx_r + IDX_W'(1);
        end else begin
            acc_r <= acc_r;
            idx_r <= idx_r;
        end
    end

endmodule

// File: rtl/uart_frame_loader.sv
// Host-to-FPGA frame loader: parses WRITE / FILL / MODE frames from a UART byte stream,
// issues held write requests to one of CHANNELS targets and answers with a status byte.
import uart_frame_pkg::*;

module uart_frame_loader #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int CHANNELS    = 4,
    parameter int TIMEOUT_CYC = 27_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_data_valid,
    output logic              rx_data_ready,
    output logic [7:0]        tx_data,
    output logic              tx_data_valid,
    input  logic              tx_data_ready,
    output logic              wr_en,
    input  logic              wr_ready,
    output logic [3:0]        wr_sel,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [7:0]        mode_q,
    output logic              mode_we,
    output logic              busy
);

    localparam int ADDR_B = (ADDR_W + 7) / 8;
    localparam int DATA_B = DATA_W / 8;
    localparam int IDX_W  = $clog2(max3(ADDR_B, DATA_B, 2));
    localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);

    state_e              state_r;
    logic                rx_data_ready_r;
    logic [7:0]          tx_data_r;
    logic                tx_data_valid_r;
    logic                wr_en_r;
    logic [3:0]          wr_sel_r;
    logic [ADDR_W-1:0]   wr_addr_r;
    logic [DATA_W-1:0]   wr_data_r;
    logic [7:0]          mode_q_r;
    logic                mode_we_r;
    logic                busy_r;
    logic                err_r;
    logic                fill_r;
    logic                is_mode_r;
    logic [15:0]         cnt_r;
    logic [7:0]          sum_r;
    logic [7:0]          mode_byte_r;
    logic [7:0]          resp_r;
    logic                resp_loaded_r;
    logic [WAIT_W-1:0]   wait_r;

    logic                acc_s;
    logic                timed_s;
    logic                timeout_s;
    logic                clear_s;
    logic                addr_last_s;
    logic                cnt_last_s;
    logic                data_last_s;
    logic [ADDR_B*8-1:0] addr_val_s;
    logic [15:0]         cnt_val_s;
    logic [DATA_B*8-1:0] data_val_s;
    logic [7:0]          csum_next_s;

    assign acc_s       = rx_data_valid && rx_data_ready_r;
    assign clear_s     = (state_r == S_IDLE);
    assign csum_next_s = csum_add(sum_r, rx_data);

    // States that wait on the host and are therefore guarded by the inter-byte timeout.
    always_comb begin
        case (state_r)
            S_ADDR, S_CNT, S_DATA, S_MODE, S_CSUM: timed_s = 1'b1;
            default:                               timed_s = 1'b0;
        endcase
        if (timed_s && !acc_s && (wait_r == WAIT_W'(TIMEOUT_CYC - 1))) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
    end

    frame_field_shift #(.NB(ADDR_B), .IDX_W(IDX_W)) u_addr_shift (
        .clk   (clk),
        .rst   (rst),
        .clear (clear_s),
        .load  (acc_s && (state_r == S_ADDR)),
        .din   (rx_data),
        .last  (addr_last_s),
        .value (addr_val_s)
    );

    frame_field_shift #(.NB(2), .IDX_W(IDX_W)) u_cnt_shift (
        .clk   (clk),
        .rst   (rst),
        .clear (clear_s),
        .load  (acc_s && (state_r == S_CNT)),
        .din   (rx_data),
        .last  (cnt_last_s),
        .value (cnt_val_s)
    );

    frame_field_shift #(.NB(DATA_B), .IDX_W(IDX_W)) u_data_shift (
        .clk   (clk),
        .rst   (rst),
        .clear (clear_s),
        .load  (acc_s && (state_r == S_DATA)),
        .din   (rx_data),
        .last  (data_last_s),
        .value (data_val_s)
    );

    // Inter-byte wait counter; only runs while a frame is waiting on host bytes.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_r <= '0;
        end else if (acc_s || !timed_s) begin
            wait_r <= '0;
        end else begin
            wait_r <= wait_r + WAIT_W'(1);
        end
    end

    // Frame FSM with all registered outputs; rx_data_ready and busy are updated on each transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= S_IDLE;
            rx_data_ready_r <= 1'b1;
            tx_data_r       <= 8'h00;
            tx_data_valid_r <= 1'b0;
            wr_en_r         <= 1'b0;
            wr_sel_r        <= 4'd0;
            wr_addr_r       <= '0;
            wr_data_r       <= '0;
            mode_q_r        <= 8'h00;
            mode_we_r       <= 1'b0;
            busy_r          <= 1'b0;
            err_r           <= 1'b0;
            fill_r          <= 1'b0;
            is_mode_r       <= 1'b0;
            cnt_r           <= 16'd0;
            sum_r           <= 8'h00;
            mode_byte_r     <= 8'h00;
            resp_r          <= 8'h00;
            resp_loaded_r   <= 1'b0;
        end else begin
            mode_we_r <= 1'b0;
            if (tx_data_valid_r && tx_data_ready) begin
                tx_data_valid_r <= 1'b0;
            end
            if (rx_data_valid && !rx_data_ready_r) begin
                err_r <= 1'b1;
            end

            if (timeout_s) begin
                tx_data_r       <= ABORT;
                tx_data_valid_r <= 1'b1;
                state_r         <= S_IDLE;
                busy_r          <= 1'b0;
                rx_data_ready_r <= 1'b1;
            end else begin
                case (state_r)
                    S_IDLE: begin
                        err_r <= 1'b0;
                        if (acc_s) begin
                            sum_r    <= rx_data;
                            wr_sel_r <= rx_data[3:0];
                            // MODE is decoded first so it wins over FILL channel 13 when CHANNELS=16.
                            if (rx_data == CMD_MODE) begin
                                is_mode_r <= 1'b1;
                                state_r   <= S_MODE;
                                busy_r    <= 1'b1;
                            end else if (rx_data < 8'(CHANNELS)) begin
                                is_mode_r <= 1'b0;
                                fill_r    <= 1'b0;
                                state_r   <= S_ADDR;
                                busy_r    <= 1'b1;
                            end else if ((rx_data >= CMD_FILL_BASE) &&
                                         (rx_data < (CMD_FILL_BASE + 8'(CHANNELS)))) begin
                                is_mode_r <= 1'b0;
                                fill_r    <= 1'b1;
                                state_r   <= S_ADDR;
                                busy_r    <= 1'b1;
                            end else begin
                                tx_data_r       <= BADCMD;
                                tx_data_valid_r <= 1'b1;
                            end
                        end
                    end
                    S_ADDR: begin
                        if (acc_s) begin
                            sum_r <= csum_next_s;
                            if (addr_last_s) begin
                                wr_addr_r <= addr_val_s[ADDR_W-1:0];
                                state_r   <= S_CNT;
                            end
                        end
                    end
                    S_CNT: begin
                        if (acc_s) begin
                            sum_r <= csum_next_s;
                            if (cnt_last_s) begin
                                cnt_r   <= cnt_val_s;
                                state_r <= S_DATA;
                            end
                        end
                    end
                    S_DATA: begin
                        if (acc_s) begin
                            sum_r <= csum_next_s;
                            if (data_last_s) begin
                                wr_data_r       <= data_val_s[DATA_W-1:0];
                                wr_en_r         <= 1'b1;
                                state_r         <= S_WRITE;
                                rx_data_ready_r <= 1'b0;
                            end
                        end
                    end
                    S_WRITE: begin
                        if (wr_en_r && wr_ready) begin
                            wr_en_r   <= 1'b0;
                            wr_addr_r <= wr_addr_r + ADDR_W'(1);
                            if (cnt_r == 16'd0) begin
                                state_r         <= S_CSUM;
                                rx_data_ready_r <= 1'b1;
                            end else begin
                                cnt_r <= cnt_r - 16'd1;
                                if (fill_r) begin
                                    state_r <= S_FILL_W;
                                end else begin
                                    state_r         <= S_DATA;
                                    rx_data_ready_r <= 1'b1;
                                end
                            end
                        end
                    end
                    S_FILL_W: begin
                        wr_en_r <= 1'b1;
                        state_r <= S_WRITE;
                    end
                    S_MODE: begin
                        if (acc_s) begin
                            sum_r       <= csum_next_s;
                            mode_byte_r <= rx_data;
                            state_r     <= S_CSUM;
                        end
                    end
                    S_CSUM: begin
                        if (acc_s) begin
                            if ((csum_next_s == 8'h00) && !err_r) begin
                                resp_r <= ACK;
                                if (is_mode_r) begin
                                    mode_q_r  <= mode_byte_r;
                                    mode_we_r <= 1'b1;
                                end
                            end else begin
                                resp_r <= NAK;
                            end
                            resp_loaded_r   <= 1'b0;
                            state_r         <= S_RESP;
                            rx_data_ready_r <= 1'b0;
                        end
                    end
                    S_RESP: begin
                        // Wait for any earlier status byte to drain before presenting the response.
                        if (!resp_loaded_r) begin
                            if (!tx_data_valid_r) begin
                                tx_data_r       <= resp_r;
                                tx_data_valid_r <= 1'b1;
                                resp_loaded_r   <= 1'b1;
                            end
                        end else if (tx_data_valid_r && tx_data_ready) begin
                            state_r         <= S_IDLE;
                            busy_r          <= 1'b0;
                            rx_data_ready_r <= 1'b1;
                        end
                    end
                    default: begin
                        wr_en_r         <= 1'b0;
                        state_r         <= S_IDLE;
                        busy_r          <= 1'b0;
                        rx_data_ready_r <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign rx_data_ready = rx_data_ready_r;
    assign tx_data       = tx_data_r;
    assign tx_data_valid = tx_data_valid_r;
    assign wr_en         = wr_en_r;
    assign wr_sel        = wr_sel_r;
    assign wr_addr       = wr_addr_r;
    assign wr_data       = wr_data_r;
    assign mode_q        = mode_q_r;
    assign mode_we       = mode_we_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Scoreboard bench for uart_frame_loader: expected writes, status bytes and mode updates are queued
// as frames are sent and compared when the DUT presents them.
module tb_uart_frame_loader;

    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 16;
    localparam int CHANNELS    = 4;
    localparam int TIMEOUT_CYC = 1000;

    logic              clk;
    logic              rst;
    logic [7:0]        rx_data;
    logic              rx_data_valid;
    logic              rx_data_ready;
    logic [7:0]        tx_data;
    logic              tx_data_valid;
    logic              tx_data_ready;
    logic              wr_en;
    logic              wr_ready;
    logic [3:0]        wr_sel;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [7:0]        mode_q;
    logic              mode_we;
    logic              busy;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [35:0] exp_wr_q[$];
    logic [7:0]  exp_tx_q[$];
    logic [7:0]  exp_mode_q[$];
    logic [7:0]  frame_q[$];
    logic        wr_hold  = 1'b0;
    logic        rand_rdy = 1'b0;
    logic        pend_r   = 1'b0;
    logic        pend_rst = 1'b0;
    logic [35:0] pend_v   = 36'd0;
    int          to_cyc;

    uart_frame_loader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CHANNELS(CHANNELS), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_data_valid(rx_data_valid), .rx_data_ready(rx_data_ready),
        .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_data_ready(tx_data_ready),
        .wr_en(wr_en), .wr_ready(wr_ready), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
        .mode_q(mode_q), .mode_we(mode_we), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish (tests %0d)", n_tests);
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Target and uart_tx handshakes driven just after each rising edge.
    initial begin
        wr_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            wr_ready = wr_hold ? 1'b0 : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    initial begin
        tx_data_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            tx_data_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor on the falling edge: handshakes pop the scoreboard, held writes must stay stable.
    always @(negedge clk) begin
        if (pend_r && !pend_rst) begin
            check_eq("wr_hold_en", {63'd0, wr_en}, 64'd1);
            check_eq("wr_hold_val", {28'd0, wr_sel, wr_addr, wr_data}, {28'd0, pend_v});
        end
        pend_r   <= wr_en && !wr_ready;
        pend_rst <= rst;
        pend_v   <= {wr_sel, wr_addr, wr_data};
        if (wr_en && wr_ready) begin
            if (exp_wr_q.size() == 0) check_eq("wr_extra", 64'(exp_wr_q.size()), 64'd1);
            else check_eq("wr", {28'd0, wr_sel, wr_addr, wr_data}, {28'd0, exp_wr_q.pop_front()});
        end
        if (tx_data_valid && tx_data_ready) begin
            if (exp_tx_q.size() == 0) check_eq("tx_extra", 64'(exp_tx_q.size()), 64'd1);
            else check_eq("tx", {56'd0, tx_data}, {56'd0, exp_tx_q.pop_front()});
        end
        if (mode_we) begin
            if (exp_mode_q.size() == 0) check_eq("mode_extra", 64'(exp_mode_q.size()), 64'd1);
            else check_eq("mode_q", {56'd0, mode_q}, {56'd0, exp_mode_q.pop_front()});
        end
    end

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        while (!rx_data_ready && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 3000) check_eq("rx_rdy_timeout", {63'd0, rx_data_ready}, 64'd1);
        rx_data       = b;
        rx_data_valid = 1'b1;
        @(posedge clk); #1;
        rx_data_valid = 1'b0;
    endtask

    task automatic send_frame(input logic bad);
        logic [7:0] s = 8'h00;
        foreach (frame_q[i]) begin
            s = s + frame_q[i];
            send_byte(frame_q[i]);
        end
        send_byte((8'h00 - s) + {7'd0, bad});
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_wr_q.size() + exp_tx_q.size() + exp_mode_q.size()) != 0 && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("drain", 64'(exp_wr_q.size() + exp_tx_q.size() + exp_mode_q.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("busy_idle", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        rst           = 1'b1;
        rx_data       = 8'h00;
        rx_data_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_rx_ready", {63'd0, rx_data_ready}, 64'd1);
        check_eq("rst_tx_valid", {63'd0, tx_data_valid}, 64'd0);
        check_eq("rst_tx_data", {56'd0, tx_data}, 64'd0);
        check_eq("rst_wr_en", {63'd0, wr_en}, 64'd0);
        check_eq("rst_wr_fields", {28'd0, wr_sel, wr_addr, wr_data}, 64'd0);
        check_eq("rst_mode", {55'd0, mode_we, mode_q}, 64'd0);
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // WRITE ch2, two words
        frame_q = '{8'h02, 8'h34, 8'h12, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hFE, 8'hCA};
        exp_wr_q.push_back({4'd2, 16'h1234, 16'hBEEF});
        exp_wr_q.push_back({4'd2, 16'h1235, 16'hCAFE});
        exp_tx_q.push_back(8'h06);
        send_frame(1'b0);
        drain();

        // FILL ch0 across the address wrap, random wr_ready
        rand_rdy = 1'b1;
        frame_q = '{8'h40, 8'hFE, 8'hFF, 8'h03, 8'h00, 8'hAA, 8'h00};
        exp_wr_q.push_back({4'd0, 16'hFFFE, 16'h00AA});
        exp_wr_q.push_back({4'd0, 16'hFFFF, 16'h00AA});
        exp_wr_q.push_back({4'd0, 16'h0000, 16'h00AA});
        exp_wr_q.push_back({4'd0, 16'h0001, 16'h00AA});
        exp_tx_q.push_back(8'h06);
        send_frame(1'b0);
        drain();
        rand_rdy = 1'b0;

        // MODE with bad then good checksum
        frame_q = '{8'h4D, 8'h07};
        exp_tx_q.push_back(8'h15);
        send_frame(1'b1);
        drain();
        check_eq("mode_unchanged", {56'd0, mode_q}, 64'd0);
        exp_mode_q.push_back(8'h07);
        exp_tx_q.push_back(8'h06);
        send_frame(1'b0);
        drain();
        check_eq("mode_set", {56'd0, mode_q}, 64'h07);
        check_eq("mode_we_low", {63'd0, mode_we}, 64'd0);

        // Unknown command, then a normal single-word write
        exp_tx_q.push_back(8'h3F);
        send_byte(8'h09);
        drain();
        frame_q = '{8'h03, 8'h10, 8'h00, 8'h00, 8'h00, 8'h57, 8'h13};
        exp_wr_q.push_back({4'd3, 16'h0010, 16'h1357});
        exp_tx_q.push_back(8'h06);
        send_frame(1'b0);
        drain();

        // Timeout after the address field
        exp_tx_q.push_back(8'h18);
        send_byte(8'h02);
        send_byte(8'h34);
        send_byte(8'h12);
        to_cyc = 0;
        while (!tx_data_valid && to_cyc < 2000) begin
            @(posedge clk); #1;
            to_cyc++;
        end
        check_eq("timeout_cycles", 64'(to_cyc), 64'(TIMEOUT_CYC));
        drain();

        // Overrun while a write is stalled: writes still happen, frame ends in NAK
        wr_hold = 1'b1;
        exp_wr_q.push_back({4'd1, 16'h0000, 16'h1111});
        exp_wr_q.push_back({4'd1, 16'h0001, 16'h2222});
        exp_tx_q.push_back(8'h15);
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h11); send_byte(8'h11);
        check_eq("stall_rx_ready", {63'd0, rx_data_ready}, 64'd0);
        rx_data       = 8'h55;
        rx_data_valid = 1'b1;
        @(posedge clk); #1;
        rx_data_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        wr_hold = 1'b0;
        send_byte(8'h22); send_byte(8'h22); send_byte(8'h98);
        drain();

        // Reset while a write is held
        wr_hold = 1'b1;
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h34); send_byte(8'h12);
        check_eq("pre_rst_wr_en", {63'd0, wr_en}, 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_wr_en", {63'd0, wr_en}, 64'd0);
        check_eq("mid_rst_fields", {28'd0, wr_sel, wr_addr, wr_data}, 64'd0);
        check_eq("mid_rst_ctrl", {60'd0, busy, rx_data_ready, tx_data_valid, mode_we}, 64'h4);
        check_eq("mid_rst_mode", {56'd0, mode_q}, 64'd0);
        @(posedge clk); #1;
        wr_hold = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        frame_q = '{8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'hA5, 8'hA5};
        exp_wr_q.push_back({4'd0, 16'h0005, 16'hA5A5});
        exp_tx_q.push_back(8'h06);
        send_frame(1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
